// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO controller: per-pin direction, synchronised and optionally
// debounced inputs, and edge interrupts with sticky write-1-to-clear pending bits.
module wb_gpio_irq #(
    parameter int unsigned NGPIO = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [NGPIO-1:0] gpio_i,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam int unsigned DW = 32;

    localparam logic [2:0] REG_IN      = 3'd0;
    localparam logic [2:0] REG_OUT     = 3'd1;
    localparam logic [2:0] REG_DIR     = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_PEND    = 3'd5;
    localparam logic [2:0] REG_DIV     = 3'd6;

    logic [NGPIO-1:0] out_q;
    logic [NGPIO-1:0] dir_q;
    logic [NGPIO-1:0] rise_en_q;
    logic [NGPIO-1:0] fall_en_q;
    logic [NGPIO-1:0] pend_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] presc_q;
    logic [NGPIO-1:0] sync1_q;
    logic [NGPIO-1:0] sync2_q;
    logic [NGPIO-1:0] hist_a_q;
    logic [NGPIO-1:0] hist_b_q;
    logic [NGPIO-1:0] filt_q;
    logic [NGPIO-1:0] filt_d_q;
    logic             ack_q;
    logic [DW-1:0]    dat_q;

    logic             req_c;
    logic             wr_c;
    logic [2:0]       reg_sel_c;
    logic [DW-1:0]    byte_mask_c;
    logic [NGPIO-1:0] pin_mask_c;
    logic [NGPIO-1:0] pin_wdat_c;
    logic [DIV_W-1:0] div_mask_c;
    logic [DIV_W-1:0] div_wdat_c;
    logic [DW-1:0]    rdata_c;
    logic             tick_c;
    logic [NGPIO-1:0] stable_c;
    logic [NGPIO-1:0] edge_c;
    logic [NGPIO-1:0] clr_c;
    logic             unused_c;

    function automatic logic [NGPIO-1:0] merge_pins(input logic [NGPIO-1:0] old_v,
                                                   input logic [NGPIO-1:0] new_v,
                                                   input logic [NGPIO-1:0] mask_v);
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

    // Bus decode: a request is a strobe seen while no ack is outstanding.
    always_comb begin
        req_c       = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_c        = req_c & wb_we_i;
        reg_sel_c   = wb_adr_i[4:2];
        byte_mask_c = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        pin_mask_c  = byte_mask_c[NGPIO-1:0];
        pin_wdat_c  = wb_dat_i[NGPIO-1:0];
        div_mask_c  = byte_mask_c[DIV_W-1:0];
        div_wdat_c  = wb_dat_i[DIV_W-1:0];
    end

    assign unused_c = ^{wb_adr_i, wb_dat_i, byte_mask_c};

    // Read mux, sampled into wb_dat_o on the acking edge.
    always_comb begin
        rdata_c = '0;
        case (reg_sel_c)
            REG_IN:      rdata_c = DW'(filt_q);
            REG_OUT:     rdata_c = DW'(out_q);
            REG_DIR:     rdata_c = DW'(dir_q);
            REG_RISE_EN: rdata_c = DW'(rise_en_q);
            REG_FALL_EN: rdata_c = DW'(fall_en_q);
            REG_PEND:    rdata_c = DW'(pend_q);
            REG_DIV:     rdata_c = DW'(div_q);
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req_c;
            dat_q <= req_c ? rdata_c : '0;
        end
    end

    // Control registers; byte enables gate every field.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            div_q     <= '0;
        end else if (wr_c) begin
            case (reg_sel_c)
                REG_OUT:     out_q     <= merge_pins(out_q, pin_wdat_c, pin_mask_c);
                REG_DIR:     dir_q     <= merge_pins(dir_q, pin_wdat_c, pin_mask_c);
                REG_RISE_EN: rise_en_q <= merge_pins(rise_en_q, pin_wdat_c, pin_mask_c);
                REG_FALL_EN: fall_en_q <= merge_pins(fall_en_q, pin_wdat_c, pin_mask_c);
                REG_DIV:     div_q     <= (div_q & ~div_mask_c) | (div_wdat_c & div_mask_c);
                default:     ;
            endcase
        end
    end

    // Shared debounce prescaler; a DIV write restarts the count.
    always_comb begin
        tick_c = (div_q != '0) && (presc_q == div_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc_q <= '0;
        end else if (wr_c && reg_sel_c == REG_DIV) begin
            presc_q <= '0;
        end else if (presc_q == div_q) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    // Synchroniser and filter: a pin follows sync only after three equal tick samples.
    always_comb begin
        stable_c = ~(sync2_q ^ hist_a_q) & ~(sync2_q ^ hist_b_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            hist_a_q <= '0;
            hist_b_q <= '0;
            filt_q   <= '0;
            filt_d_q <= '0;
        end else begin
            sync1_q  <= gpio_i;
            sync2_q  <= sync1_q;
            filt_d_q <= filt_q;
            if (div_q == '0) begin
                filt_q <= sync2_q;
            end else if (tick_c) begin
                filt_q   <= (filt_q & ~stable_c) | (sync2_q & stable_c);
                hist_a_q <= sync2_q;
                hist_b_q <= hist_a_q;
            end
        end
    end

    // Edge detect and sticky pending; a new edge beats a same-cycle clear.
    always_comb begin
        edge_c = (filt_q & ~filt_d_q & rise_en_q) | (~filt_q & filt_d_q & fall_en_q);
        clr_c  = (wr_c && reg_sel_c == REG_PEND) ? (pin_wdat_c & pin_mask_c) : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_c) | edge_c;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = |pend_q;

endmodule

// File: doc/wb_gpio_irq.md
# wb_gpio_irq

Parametrised Wishbone GPIO controller, successor to the fixed 16-in/16-out GPIO peripheral on the SoC bus. It provides NGPIO bidirectional pins with per-pin direction, two-flop input synchronisation, an optional shared-prescaler debounce filter, and per-pin rising/falling edge interrupts with sticky write-1-to-clear pending bits. It sits as a Wishbone classic slave on the CPU interconnect; pads are driven through BB-type buffers at the top level using gpio_o/gpio_oe_o.

## Interface
- NGPIO, 16, number of pins (1..32); unused upper register bits read 0, writes ignored
- DIV_W, 16, width of debounce prescaler register/counter
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous, active-high reset
- wb_adr_i  in  32  byte address; only [4:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, valid while wb_ack_o high
- wb_ack_o  out  1  transfer acknowledge
- gpio_i  in  NGPIO  pad inputs (asynchronous)
- gpio_o  out  NGPIO  pad output values
- gpio_oe_o  out  NGPIO  pad output enables, 1 = drive
- irq_o  out  1  level interrupt, OR of all pending bits

## Operation
- Register map (adr[4:2]): 0 IN (RO, filtered input), 1 OUT (RW), 2 DIR (RW, 1=output), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 PEND (R, W1C), 6 DIV (RW, DIV_W bits), 7 reserved (reads 0, writes ignored).
- Writes to RW registers honour wb_sel_i per byte; PEND W1C also masked by wb_sel_i.
- gpio_o = OUT; gpio_oe_o = DIR.
- Input path: gpio_i -> 2-flop synchroniser (sync) -> filter -> filt. IN reads filt for all pins, including outputs (pad loopback).
- Filter: DIV=0 -> filt = sync (bypass). DIV>0 -> prescaler counts 0..DIV, tick when count==DIV then wraps to 0; on each tick each pin shifts sync into a 2-bit history; filt[i] updates to sync[i] only when sync[i] equals both history bits (stable 3 ticks). Writing DIV resets prescaler count to 0.
- Edge detect: filt_d = filt delayed one cycle. rise = filt & ~filt_d & RISE_EN; fall = ~filt & filt_d & FALL_EN.
- PEND[i] set on rise[i]|fall[i]; cleared by write with 1 in bit i. Set and clear in same cycle: set wins (bit stays 1).
- Enabling RISE_EN/FALL_EN never creates a pending bit for a level already present.
- irq_o = |PEND (registered PEND, combinational OR).

## Timing
- Reset: OUT=0, DIR=0 (all inputs), RISE_EN=0, FALL_EN=0, PEND=0, DIV=0, prescaler=0, sync/filt/filt_d/history=0, wb_ack_o=0, wb_dat_o=0, gpio_o=0, gpio_oe_o=0, irq_o=0.
- Ack: wb_ack_o registered; asserted the cycle after cyc&stb sampled high with ack low; high exactly one cycle; minimum 2 cycles per transfer. Dropping cyc/stb before ack aborts: no ack, no write.
- Writes commit on the same edge that raises wb_ack_o; gpio_o/gpio_oe_o change in that cycle.
- Read data reflects register state at the cycle stb is sampled.
- Input latency, bypass: pad edge -> IN visible after 3 clocks (2 sync + filt reg); PEND set 1 cycle after filt changes; irq_o same cycle as PEND.
- Reset mid-transfer: ack suppressed, all state to reset values on that edge.

## Test plan
- Reset then read all 8 registers -> all 0; irq_o=0, gpio_oe_o=0.
- Write DIR=0x00FF sel=4'b0001, OUT=0xA5A5 sel=4'b1111 -> gpio_oe_o=0x00FF, gpio_o=0xA5A5, each ack one cycle after stb, one cycle wide; write DIR with sel=4'b0010 data 0xFFFF -> DIR=0xFFFF.
- RISE_EN=0x0001, DIV=0; drive gpio_i[0] 0->1 -> PEND=0x0001 and irq_o=1 at clock 4 after edge; falling edge -> no new pending; write PEND=0x0001 -> PEND=0, irq_o=0.
- FALL_EN=0x0002; W1C PEND bit1 issued in the same cycle a falling edge on pin1 reaches edge detect -> PEND[1]=1 (set wins).
- DIV=3; glitch gpio_i[2] high for 6 clocks -> IN[2] stays 0; hold high 20 clocks -> IN[2]=1 within 3 ticks (≤12 clocks + 2 sync) of stable level.
- Assert wb_rst_i during a pending write ack cycle with PEND=0xFFFF, OUT=0xFFFF -> next cycle all registers and outputs 0, no ack.
